// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: OPMODE-selected X/Z operands, add/sub with
// selectable carry-in, optional P/CARRYOUT register with P feedback and cascade out.
module dsp_post_adder_acc #(
  parameter int    PREG       = 1,
  parameter int    CARRYINREG = 1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cep,
  input  logic        cecarryin,
  input  logic [35:0] m,
  input  logic [47:0] dab,
  input  logic [47:0] c,
  input  logic [47:0] pcin,
  input  logic        carryin,
  input  logic [7:0]  opmode,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout,
  output logic        carryoutf
);

  logic [47:0] p_reg, fb, x, z;
  logic        carryout_reg, cyi_reg, cy_src, cyi;
  logic [48:0] xc, sum;
  logic        unused;

  assign unused = ^{opmode[6], opmode[4]};

  generate
    if (CARRYINSEL == "OPMODE5") begin : g_cy_op5
      assign cy_src = opmode[5];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cy_pin
      assign cy_src = carryin;
    end else begin : g_cy_zero
      assign cy_src = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cyi_reg <= 1'b0;
    else if (cecarryin) cyi_reg <= cy_src;
  end

  assign cyi = (CARRYINREG != 0) ? cyi_reg : cy_src;

  // Without the P register the feedback taps read zero, so no combinational loop forms.
  assign fb = (PREG != 0) ? p_reg : 48'd0;

  always_comb begin
    x = 48'd0;
    case (opmode[1:0])
      2'd0: x = 48'd0;
      2'd1: x = {12'd0, m};
      2'd2: x = fb;
      2'd3: x = dab;
      default: x = 48'd0;
    endcase
  end

  always_comb begin
    z = 48'd0;
    case (opmode[3:2])
      2'd0: z = 48'd0;
      2'd1: z = pcin;
      2'd2: z = fb;
      2'd3: z = c;
      default: z = 48'd0;
    endcase
  end

  // Carry-in joins X before the subtract, so bit 48 is the borrow.
  assign xc  = {1'b0, x} + {48'd0, cyi};
  assign sum = opmode[7] ? ({1'b0, z} - xc) : ({1'b0, z} + xc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg        <= 48'd0;
      carryout_reg <= 1'b0;
    end else if (cep) begin
      p_reg        <= sum[47:0];
      carryout_reg <= sum[48];
    end
  end

  assign p         = (PREG != 0) ? p_reg : sum[47:0];
  assign carryout  = (PREG != 0) ? carryout_reg : sum[48];
  assign pcout     = p;
  assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed + randomized checks of dsp_post_adder_acc in three configurations
// against an arithmetic reference model.
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cep = 1'b1;
  logic        cecarryin = 1'b1;
  logic [35:0] m = '0;
  logic [47:0] dab = '0;
  logic [47:0] c = '0;
  logic [47:0] pcin = '0;
  logic        carryin = 1'b0;
  logic [7:0]  opmode = '0;

  logic [47:0] p_o [3];
  logic [47:0] pc_o [3];
  logic        co_o [3];
  logic        cof_o [3];

  int total = 0;
  int bad = 0;

  // model state for the two registered instances
  logic [47:0] pm [2];
  logic        com [2];
  logic        cym [2];

  always #5 clk = ~clk;

  dsp_post_adder_acc #(.PREG(1), .CARRYINREG(1), .CARRYINSEL("OPMODE5")) u_op5 (
    .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin), .m(m), .dab(dab), .c(c),
    .pcin(pcin), .carryin(carryin), .opmode(opmode),
    .p(p_o[0]), .pcout(pc_o[0]), .carryout(co_o[0]), .carryoutf(cof_o[0]));

  dsp_post_adder_acc #(.PREG(1), .CARRYINREG(1), .CARRYINSEL("CARRYIN")) u_pin (
    .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin), .m(m), .dab(dab), .c(c),
    .pcin(pcin), .carryin(carryin), .opmode(opmode),
    .p(p_o[1]), .pcout(pc_o[1]), .carryout(co_o[1]), .carryoutf(cof_o[1]));

  dsp_post_adder_acc #(.PREG(0), .CARRYINREG(0), .CARRYINSEL("OPMODE5")) u_comb (
    .clk(clk), .rst(rst), .cep(cep), .cecarryin(cecarryin), .m(m), .dab(dab), .c(c),
    .pcin(pcin), .carryin(carryin), .opmode(opmode),
    .p(p_o[2]), .pcout(pc_o[2]), .carryout(co_o[2]), .carryoutf(cof_o[2]));

  function automatic logic [48:0] calc(input logic [7:0] op, input logic [47:0] fb, input logic cy);
    logic [48:0] x, z;
    case (op[1:0])
      2'd0: x = '0;
      2'd1: x = {13'd0, m};
      2'd2: x = {1'b0, fb};
      default: x = {1'b0, dab};
    endcase
    case (op[3:2])
      2'd0: z = '0;
      2'd1: z = {1'b0, pcin};
      2'd2: z = {1'b0, fb};
      default: z = {1'b0, c};
    endcase
    return op[7] ? (z - x - {48'd0, cy}) : (z + x + {48'd0, cy});
  endfunction

  task automatic chk(input string tag, input logic [48:0] got, input logic [48:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      pm[k] = '0; com[k] = 1'b0; cym[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [48:0] e;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("p%0d", k), {1'b0, p_o[k]}, {1'b0, pm[k]});
      chk($sformatf("pcout%0d", k), {1'b0, pc_o[k]}, {1'b0, pm[k]});
      chk($sformatf("co%0d", k), {48'd0, co_o[k]}, {48'd0, com[k]});
      chk($sformatf("cof%0d", k), {48'd0, cof_o[k]}, {48'd0, com[k]});
    end
    e = calc(opmode, 48'd0, opmode[5]);
    chk("p_comb", {1'b0, p_o[2]}, {1'b0, e[47:0]});
    chk("pcout_comb", {1'b0, pc_o[2]}, {1'b0, e[47:0]});
    chk("co_comb", {48'd0, co_o[2]}, {48'd0, e[48]});
  endtask

  // one clock edge: advance the model with the inputs present at the edge, then check
  task automatic step();
    logic [48:0] s;
    @(posedge clk);
    if (rst) model_clear();
    else begin
      for (int k = 0; k < 2; k++) begin
        s = calc(opmode, pm[k], cym[k]);
        if (cep) begin
          pm[k] = s[47:0]; com[k] = s[48];
        end
        if (cecarryin) cym[k] = (k == 0) ? opmode[5] : carryin;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    model_clear();
    // reset holds outputs at zero despite enabled operands
    opmode = 8'h05; m = 36'hFFFFFFFFF; pcin = '0;
    #1;
    chk("rst_async_p", {1'b0, p_o[0]}, 49'd0);
    step();
    chk("rst_hold_p", {1'b0, p_o[0]}, 49'd0);
    chk("rst_hold_co", {48'd0, co_o[0]}, 49'd0);
    rst = 1'b0;
    step();
    chk("rst_release_p", {1'b0, p_o[0]}, 49'h0_000F_FFFF_FFFF);

    // accumulate from reset
    #2 rst = 1'b1; #1 rst = 1'b0; model_clear();
    opmode = 8'h09; m = 36'd10;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("acc%0d", i), {1'b0, p_o[0]}, 49'(10 * i));
    end
    cep = 1'b0;
    step(); step();
    chk("acc_hold", {1'b0, p_o[0]}, 49'd40);
    cep = 1'b1;
    #2 rst = 1'b1;
    #1 chk("acc_rst_async", {1'b0, p_o[0]}, 49'd0);
    model_clear();
    step();
    rst = 1'b0;

    // subtract and borrow
    opmode = 8'h8D; c = 48'd100; m = 36'd30;
    step();
    chk("sub_p", {1'b0, p_o[0]}, 49'd70);
    chk("sub_co", {48'd0, co_o[0]}, 49'd0);
    m = 36'd130;
    step();
    chk("borrow_p", {1'b0, p_o[0]}, 49'h0_FFFF_FFFF_FFE2);
    chk("borrow_co", {48'd0, co_o[0]}, 49'd1);

    // overflow wrap
    opmode = 8'h0F; c = 48'hFFFF_FFFF_FFFF; dab = 48'd1;
    step();
    chk("ovf_p", {1'b0, p_o[0]}, 49'd0);
    chk("ovf_co", {48'd0, co_o[0]}, 49'd1);
    dab = 48'd0;
    step();
    chk("noovf_p", {1'b0, p_o[0]}, 49'h0_FFFF_FFFF_FFFF);
    chk("noovf_co", {48'd0, co_o[0]}, 49'd0);

    // registered carry-in, one edge ahead of its operands
    opmode = 8'h21; m = 36'd5; carryin = 1'b0;
    step();
    chk("cy_op5_first", {1'b0, p_o[0]}, 49'd5);
    step();
    chk("cy_op5_p", {1'b0, p_o[0]}, 49'd6);
    opmode = 8'h01; carryin = 1'b1;
    step();
    chk("cy_pin_first", {1'b0, p_o[1]}, 49'd5);
    step();
    chk("cy_pin_p", {1'b0, p_o[1]}, 49'd6);
    cecarryin = 1'b0; opmode = 8'h21; carryin = 1'b0;
    step();
    chk("cy_stale_op5", {1'b0, p_o[0]}, 49'd5);
    chk("cy_stale_pin", {1'b0, p_o[1]}, 49'd6);
    cecarryin = 1'b1;

    // combinational cascade, no edge involved
    #1 opmode = 8'h04; pcin = 48'h1234_5678_9ABC;
    #1;
    chk("comb_p", {1'b0, p_o[2]}, 49'h0_1234_5678_9ABC);
    chk("comb_pcout", {1'b0, pc_o[2]}, 49'h0_1234_5678_9ABC);
    opmode = 8'h08;
    #1 chk("comb_nofb", {1'b0, p_o[2]}, 49'd0);
    step();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      opmode    = 8'($urandom);
      m         = {4'($urandom), 32'($urandom)};
      dab       = {16'($urandom), 32'($urandom)};
      c         = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), 32'($urandom)};
      pcin      = {16'($urandom), 32'($urandom)};
      carryin   = 1'($urandom);
      cep       = ($urandom_range(0, 4) != 0);
      cecarryin = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 39) == 0);
      step();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
